tdm_demux2: RTL and testbench

TDM_DEMUX2 -- requirements
Module: tdm_demux2

---
 rtl/tdm_demux2_pkg.sv | 27 ++
 rtl/tdm_demux2_if.sv | 42 ++++
 rtl/tdm_demux2_fifo.sv | 61 ++++++
 rtl/tdm_demux2.sv | 103 ++++++++++
 tb/tb_tdm_demux2.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/tdm_demux2_pkg.sv
// rtl/tdm_demux2_pkg.sv - shared constants and routing helper for the two-channel TDM demux
package tdm_demux_pkg;

  localparam logic CH0        = 1'b0;
  localparam logic CH1        = 1'b1;
  localparam int   FIFO_DEPTH = 2;
  localparam int   DEF_WIDTH  = 8;
  localparam int   DEF_CNT_W  = 16;

  // Destination channel of the beat currently presented at the input.
  // In TDM mode a start-of-frame always lands on ch0 so frames realign.
  function automatic logic route_dest(
    input logic alt_en,
    input logic in_sel,
    input logic in_sof,
    input logic ptr
  );
    if (!alt_en) begin
      return in_sel;
    end else if (in_sof) begin
      return CH0;
    end else begin
      return ptr;
    end
  endfunction

endpackage

// File: rtl/tdm_demux2_if.sv
// rtl/tdm_demux2_if.sv - input stream, two output channels and beat counters of the demux
interface tdm_demux2_if #(
  parameter int WIDTH = tdm_demux_pkg::DEF_WIDTH,
  parameter int CNT_W = tdm_demux_pkg::DEF_CNT_W
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic             in_sof;
  logic             alt_en;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Producer of input beats and consumer of both channels
  modport master (
    output in_data, in_valid, in_sel, in_sof, alt_en,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_data, out0_valid, out1_data, out1_valid,
    input  cnt0, cnt1
  );

  // The demux itself
  modport slave (
    input  in_data, in_valid, in_sel, in_sof, alt_en,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_data, out0_valid, out1_data, out1_valid,
    output cnt0, cnt1
  );

endinterface

// File: rtl/tdm_demux2_fifo.sv
// rtl/tdm_demux2_fifo.sv - two-entry per-channel FIFO with registered storage
module demux_fifo2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == DEPTH);
  assign empty     = (r_count == 2'd0);
  // A push into a full FIFO is dropped even if a pop happens in the same
  // cycle; the upstream ready is derived from full alone.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  // Output comes straight from storage, so it is stable while not popped.
  assign dout      = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; reset clears everything including data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// rtl/tdm_demux2.sv - routes one input stream to two buffered output channels, explicit or TDM
module tdm_demux2
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  tdm_demux2_if.slave bus
);

  logic             r_ptr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_dest;
  logic             w_dest_full;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_push0;
  logic             w_push1;
  logic             w_pop0;
  logic             w_pop1;
  logic             w_full0;
  logic             w_full1;
  logic             w_empty0;
  logic             w_empty1;
  logic             w_valid0;
  logic             w_valid1;
  logic [WIDTH-1:0] w_dout0;
  logic [WIDTH-1:0] w_dout1;

  assign w_dest      = route_dest(bus.alt_en, bus.in_sel, bus.in_sof, r_ptr);
  assign w_dest_full = (w_dest == CH1) ? w_full1 : w_full0;
  // Ready depends only on the selected FIFO's fullness, never on out ready.
  assign w_in_ready  = ~rst & ~w_dest_full;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_push0     = w_accept & (w_dest == CH0);
  assign w_push1     = w_accept & (w_dest == CH1);

  // Outputs are forced quiet while reset is asserted, before the FIFOs clear.
  assign w_valid0    = ~rst & ~w_empty0;
  assign w_valid1    = ~rst & ~w_empty1;
  assign w_pop0      = w_valid0 & bus.out0_ready;
  assign w_pop1      = w_valid1 & bus.out1_ready;

  assign bus.in_ready   = w_in_ready;
  assign bus.out0_valid = w_valid0;
  assign bus.out1_valid = w_valid1;
  assign bus.out0_data  = rst ? '0 : w_dout0;
  assign bus.out1_data  = rst ? '0 : w_dout1;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push0),
    .pop   (w_pop0),
    .din   (bus.in_data),
    .dout  (w_dout0),
    .full  (w_full0),
    .empty (w_empty0)
  );

  demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push1),
    .pop   (w_pop1),
    .din   (bus.in_data),
    .dout  (w_dout1),
    .full  (w_full1),
    .empty (w_empty1)
  );

  // TDM pointer: flips away from wherever the last TDM beat went; frozen
  // in explicit mode so alternation resumes where it left off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= CH0;
    end else if (w_accept && bus.alt_en) begin
      r_ptr <= ~w_dest;
    end
  end

  // Delivered-beat counters, free-running and wrapping silently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_pop1) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux2.sv
// tb/tb_tdm_demux2.sv - directed vector bench for tdm_demux2
module tb_tdm_demux2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;

  tdm_demux2_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tdm_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       sel;
    logic       sof;
    logic       alt;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [3:0] e_c0;
    logic [3:0] e_c1;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic s, input logic sf, input logic a,
                     input logic r0, input logic r1,
                     input logic e_rdy, input logic e_v0, input logic [7:0] e_d0,
                     input logic e_v1, input logic [7:0] e_d1,
                     input logic [3:0] e_c0, input logic [3:0] e_c1);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.sel = s; t.sof = sf; t.alt = a;
    t.r0 = r0; t.r1 = r1; t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0;
    t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_c0 = e_c0; t.e_c1 = e_c1;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst            = t.rst;
    bus.in_valid   = t.vld;
    bus.in_data    = t.data;
    bus.in_sel     = t.sel;
    bus.in_sof     = t.sof;
    bus.alt_en     = t.alt;
    bus.out0_ready = t.r0;
    bus.out1_ready = t.r1;
  endtask

  initial begin
    vec_t idle;
    idle = '{default: '0};
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //   rst v  data  sel sof alt r0 r1 | rdy v0 d0    v1 d1    c0 c1
    // reset state
    add(1, 0, 8'h00, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 0, 0);
    // TDM alternation, outputs always ready
    add(0, 1, 8'h11, 0, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 8'h22, 0, 0, 1, 1, 1,   1, 1, 8'h11, 0, 8'h00, 0, 0);
    add(0, 1, 8'h33, 0, 0, 1, 1, 1,   1, 0, 8'h00, 1, 8'h22, 1, 0);
    add(0, 1, 8'h44, 0, 0, 1, 1, 1,   1, 1, 8'h33, 0, 8'h00, 1, 1);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1,   1, 0, 8'h00, 1, 8'h44, 2, 1);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 2, 2);
    // start-of-frame forces ch0, next beat goes to ch1
    add(0, 1, 8'hA1, 0, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 2, 2);
    add(0, 1, 8'hB2, 0, 1, 1, 1, 1,   1, 1, 8'hA1, 0, 8'h00, 2, 2);
    add(0, 1, 8'hC3, 0, 0, 1, 1, 1,   1, 1, 8'hB2, 0, 8'h00, 3, 2);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1,   1, 0, 8'h00, 1, 8'hC3, 4, 2);
    // explicit ch1 with consumer stalled, then draining
    add(0, 1, 8'h51, 1, 0, 0, 1, 0,   1, 0, 8'h00, 0, 8'h00, 4, 3);
    add(0, 1, 8'h52, 1, 0, 0, 1, 0,   1, 0, 8'h00, 1, 8'h51, 4, 3);
    add(0, 1, 8'h53, 1, 0, 0, 1, 0,   0, 0, 8'h00, 1, 8'h51, 4, 3);
    add(0, 1, 8'h53, 1, 0, 0, 1, 1,   0, 0, 8'h00, 1, 8'h51, 4, 3);
    add(0, 1, 8'h53, 1, 0, 0, 1, 1,   1, 0, 8'h00, 1, 8'h52, 4, 4);
    add(0, 0, 8'h00, 1, 0, 0, 1, 1,   1, 0, 8'h00, 1, 8'h53, 4, 5);
    add(0, 0, 8'h00, 1, 0, 0, 1, 1,   1, 0, 8'h00, 0, 8'h00, 4, 6);
    // ch1 fills and stalls; ch0 still streams one beat per cycle
    add(0, 1, 8'h61, 1, 0, 0, 1, 0,   1, 0, 8'h00, 0, 8'h00, 4, 6);
    add(0, 1, 8'h62, 1, 0, 0, 1, 0,   1, 0, 8'h00, 1, 8'h61, 4, 6);
    add(0, 1, 8'h71, 0, 0, 0, 1, 0,   1, 0, 8'h00, 1, 8'h61, 4, 6);
    add(0, 1, 8'h72, 0, 0, 0, 1, 0,   1, 1, 8'h71, 1, 8'h61, 4, 6);
    add(0, 1, 8'h73, 0, 0, 0, 1, 0,   1, 1, 8'h72, 1, 8'h61, 5, 6);
    add(0, 0, 8'h00, 0, 0, 0, 1, 0,   1, 1, 8'h73, 1, 8'h61, 6, 6);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0,   0, 0, 8'h00, 1, 8'h61, 7, 6);
    // fill ch0 too (last beat via TDM so ptr ends at 1), then reset
    add(0, 1, 8'h81, 0, 0, 0, 0, 0,   1, 0, 8'h00, 1, 8'h61, 7, 6);
    add(0, 1, 8'h82, 0, 0, 1, 0, 0,   1, 1, 8'h81, 1, 8'h61, 7, 6);
    add(1, 1, 8'h99, 0, 0, 1, 1, 1,   0, 0, 8'h00, 0, 8'h00, 7, 6);
    add(0, 1, 8'hA5, 0, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 1,   1, 1, 8'hA5, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1,   1, 0, 8'h00, 1, 8'hB6, 1, 0);
    add(0, 0, 8'h00, 0, 0, 1, 1, 1,   1, 0, 8'h00, 0, 8'h00, 1, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk("in_ready",   i, int'(bus.in_ready),   int'(vq[i].e_rdy));
      chk("out0_valid", i, int'(bus.out0_valid), int'(vq[i].e_v0));
      chk("out1_valid", i, int'(bus.out1_valid), int'(vq[i].e_v1));
      if (vq[i].e_v0 || vq[i].rst) chk("out0_data", i, int'(bus.out0_data), int'(vq[i].e_d0));
      if (vq[i].e_v1 || vq[i].rst) chk("out1_data", i, int'(bus.out1_data), int'(vq[i].e_d1));
      chk("cnt0", i, int'(bus.cnt0), int'(vq[i].e_c0));
      chk("cnt1", i, int'(bus.cnt1), int'(vq[i].e_c1));
    end

    // 17 back-to-back beats on ch0: counter wraps through 0 and ends at 1
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.in_valid   = (i < 17);
      bus.in_data    = 8'(i + 1);
      bus.in_sel     = 1'b0;
      bus.alt_en     = 1'b0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      #1;
      chk("wrap_ready", 100 + i, int'(bus.in_ready), 1);
      chk("wrap_valid", 100 + i, int'(bus.out0_valid), (i == 0) ? 0 : 1);
      if (i > 0) chk("wrap_data", 100 + i, int'(bus.out0_data), i);
      chk("wrap_cnt0", 100 + i, int'(bus.cnt0), (i == 0) ? 0 : ((i - 1) % 16));
      chk("wrap_out1", 100 + i, int'(bus.out1_valid), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("wrap_final_cnt0", 200, int'(bus.cnt0), 1);
    chk("wrap_final_valid", 200, int'(bus.out0_valid), 0);
    chk("wrap_final_cnt1", 200, int'(bus.cnt1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
